// File: rtl/demux16_pkg.sv
// rtl/demux16_pkg.sv - widths and helpers shared by demux16_router and demux16_slot
`include "demux16_defs.vh"

package demux16_pkg;

    localparam int WORD_W = `DEMUX16_WORD_W;
    localparam int DROP_W = `DEMUX16_DROP_W;
    localparam int STAT_W = `DEMUX16_STAT_W;

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux16_defs.vh
// rtl/demux16_defs.vh - shared width constants for the demux16 router
`ifndef DEMUX16_DEFS_VH
`define DEMUX16_DEFS_VH

`define DEMUX16_WORD_W 16
`define DEMUX16_DROP_W 8
`define DEMUX16_STAT_W 16

`endif

// File: rtl/demux16_slot.sv
// rtl/demux16_slot.sv - one-entry holding register for one router channel
// Optional delivered-word counter under DEMUX16_STATS_EN.
module demux16_slot
    import demux16_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] in_data,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid
`ifdef DEMUX16_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_cnt
`endif
);

    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              drain;

    assign drain = valid_q & out_ready;

    // A load in the same cycle as a drain keeps the slot full (back-to-back).
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = in_data;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

`ifdef DEMUX16_STATS_EN
    logic [STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (drain) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat_cnt = cnt_q;
`endif

endmodule

// File: rtl/demux16_router.sv
// rtl/demux16_router.sv - steers a 16-bit word stream to NOUT buffered channels
// Per-channel delivered counters and stat_idx/stat_cnt ports exist only with DEMUX16_STATS_EN.
module demux16_router
    import demux16_pkg::*;
#(
    parameter int NOUT  = 4,
    parameter int SEL_W = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WORD_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WORD_W*NOUT-1:0] out_data,
    output logic [NOUT-1:0]        out_valid,
    input  logic [NOUT-1:0]        out_ready,
    output logic [DROP_W-1:0]      drop_cnt
`ifdef DEMUX16_STATS_EN
    ,
    input  logic [SEL_W-1:0]       stat_idx,
    output logic [STAT_W-1:0]      stat_cnt
`endif
);

    logic [NOUT-1:0]   sel_hit;
    logic [NOUT-1:0]   load;
    logic              sel_ok;
    logic              drop;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // Out-of-range selects are always accepted so they can be discarded.
    always_comb begin
        sel_hit  = '0;
        in_ready = 1'b1;
        for (int i = 0; i < NOUT; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_hit[i] = 1'b1;
                in_ready   = ~out_valid[i] | out_ready[i];
            end
        end
    end

    assign sel_ok = |sel_hit;
    assign load   = sel_hit & {NOUT{in_valid & in_ready}};
    assign drop   = in_valid & ~sel_ok;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

`ifdef DEMUX16_STATS_EN
    logic [STAT_W-1:0] slot_cnt [NOUT];
`endif

    for (genvar g = 0; g < NOUT; g++) begin : g_slot
        demux16_slot u_slot (
            .clock     (clock),
            .reset     (reset),
            .load      (load[g]),
            .in_data   (in_data),
            .out_ready (out_ready[g]),
            .out_data  (out_data[WORD_W*g +: WORD_W]),
            .out_valid (out_valid[g])
`ifdef DEMUX16_STATS_EN
            ,
            .stat_cnt  (slot_cnt[g])
`endif
        );
    end

`ifdef DEMUX16_STATS_EN
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NOUT; i++) begin
            if (stat_idx == SEL_W'(i)) begin
                stat_cnt = slot_cnt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux16_router.sv
// tb/tb_demux16_router.sv - table-driven check of demux16_router (4- and 3-channel builds)
module tb_demux16_router;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [15:0] in_data   = '0;
    logic [1:0]  in_sel    = '0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [7:0]  drop_cnt;

    logic [15:0] in3_data  = '0;
    logic [1:0]  in3_sel   = '0;
    logic        in3_valid = 1'b0;
    logic        in3_ready;
    logic [47:0] out3_data;
    logic [2:0]  out3_valid;
    logic [2:0]  out3_ready = '0;
    logic [7:0]  drop3_cnt;

`ifdef DEMUX16_STATS_EN
    logic [1:0]  stat_idx  = '0;
    logic [15:0] stat_cnt;
    logic [1:0]  stat3_idx = '0;
    logic [15:0] stat3_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    demux16_router #(.NOUT(4), .SEL_W(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
`ifdef DEMUX16_STATS_EN
        ,
        .stat_idx  (stat_idx),
        .stat_cnt  (stat_cnt)
`endif
    );

    demux16_router #(.NOUT(3), .SEL_W(2)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in3_data),
        .in_sel    (in3_sel),
        .in_valid  (in3_valid),
        .in_ready  (in3_ready),
        .out_data  (out3_data),
        .out_valid (out3_valid),
        .out_ready (out3_ready),
        .drop_cnt  (drop3_cnt)
`ifdef DEMUX16_STATS_EN
        ,
        .stat_idx  (stat3_idx),
        .stat_cnt  (stat3_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [63:0] exp_od;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // valid sel data ordy | in_ready out_valid out_data{ch3,ch2,ch1,ch0}
        vecs[0]  = '{1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 4'b0100, 64'h0000_BEEF_0000_0000};
        vecs[1]  = '{1'b1, 2'd2, 16'h1111, 4'b0000, 1'b0, 4'b0100, 64'h0000_BEEF_0000_0000};
        vecs[2]  = '{1'b1, 2'd2, 16'h1111, 4'b0100, 1'b1, 4'b0100, 64'h0000_1111_0000_0000};
        vecs[3]  = '{1'b0, 2'd0, 16'h0000, 4'b0100, 1'b1, 4'b0000, 64'h0000_1111_0000_0000};
        vecs[4]  = '{1'b1, 2'd1, 16'h0001, 4'b1111, 1'b1, 4'b0010, 64'h0000_1111_0001_0000};
        vecs[5]  = '{1'b1, 2'd1, 16'h0002, 4'b1111, 1'b1, 4'b0010, 64'h0000_1111_0002_0000};
        vecs[6]  = '{1'b1, 2'd1, 16'h0003, 4'b1111, 1'b1, 4'b0010, 64'h0000_1111_0003_0000};
        vecs[7]  = '{1'b0, 2'd1, 16'h0000, 4'b1111, 1'b1, 4'b0000, 64'h0000_1111_0003_0000};
        vecs[8]  = '{1'b1, 2'd0, 16'hAAAA, 4'b0000, 1'b1, 4'b0001, 64'h0000_1111_0003_AAAA};
        vecs[9]  = '{1'b1, 2'd3, 16'h3333, 4'b0000, 1'b1, 4'b1001, 64'h3333_1111_0003_AAAA};
        vecs[10] = '{1'b1, 2'd0, 16'h5555, 4'b0000, 1'b0, 4'b1001, 64'h3333_1111_0003_AAAA};
        vecs[11] = '{1'b0, 2'd0, 16'h0000, 4'b1000, 1'b0, 4'b0001, 64'h3333_1111_0003_AAAA};
        vecs[12] = '{1'b1, 2'd0, 16'h5555, 4'b1001, 1'b1, 4'b0001, 64'h3333_1111_0003_5555};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_out_valid", {60'd0, out_valid}, 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_drop_cnt", {56'd0, drop_cnt}, 64'd0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            in_valid  = vecs[i].valid;
            in_sel    = vecs[i].sel;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].exp_rdy});
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_out_valid", i), {60'd0, out_valid}, {60'd0, vecs[i].exp_ov});
            chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
        end

        // Mid-stream async reset: ch0 and ch1 held, reset between clock edges
        @(negedge clock);
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h7777; out_ready = 4'b0000;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("pre_reset_out_valid", {60'd0, out_valid}, 64'h3);
        reset = 1'b1;
        #1;
        chk("async_reset_out_valid", {60'd0, out_valid}, 64'd0);
        chk("async_reset_out_data", out_data, 64'd0);
        chk("async_reset_drop_cnt", {56'd0, drop_cnt}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // NOUT=3: 300 words with bad select are accepted and dropped
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            in3_valid = 1'b1; in3_sel = 2'd3; in3_data = 16'(i);
            #1;
            chk("bad_sel_in_ready", {63'd0, in3_ready}, 64'd1);
            @(posedge clock);
            #1;
            chk("bad_sel_out_valid", {61'd0, out3_valid}, 64'd0);
            if (i == 9) chk("drop_cnt_10", {56'd0, drop3_cnt}, 64'd10);
        end
        @(negedge clock);
        in3_valid = 1'b0;
        #1;
        chk("drop_cnt_sat", {56'd0, drop3_cnt}, 64'd255);

`ifdef DEMUX16_STATS_EN
        out3_ready = 3'b010;
        for (int i = 0; i < 5; i++) begin
            in3_valid = 1'b1; in3_sel = 2'd1; in3_data = 16'(i + 1);
            @(negedge clock);
        end
        in3_valid = 1'b0;
        @(negedge clock);
        stat3_idx = 2'd1;
        #1;
        chk("stat_cnt_ch1", {48'd0, stat3_cnt}, 64'd5);
        stat3_idx = 2'd3;
        #1;
        chk("stat_cnt_oob", {48'd0, stat3_cnt}, 64'd0);
        stat3_idx = 2'd0;
        #1;
        chk("stat_cnt_ch0", {48'd0, stat3_cnt}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
